// File: rtl/dac_burst_sequencer_if.sv
// Waveform bus of one DAC channel: ROM address/data and the registered sample
// handed to the ODDR/IOBUF output stage.
interface dac_burst_sequencer_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 14
);
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;
  logic [DATA_W-1:0] dac_data;

  modport master (output rom_addr, output dac_data, input rom_data);
  modport slave  (input rom_addr, input dac_data, output rom_data);
endinterface

// File: rtl/dac_burst_sequencer.sv
// Per-channel DAC burst sequencer: ROM address generation, cycle counting and
// config/trigger gating. Define DAC_SEQ_RETRIG_EN to let triggers restart an active burst.
module dac_burst_sequencer #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 14,
  parameter int CNT_W  = 18,
  parameter int GAP_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  config_done,
  input  logic                  trig_in,
  input  logic                  trig_mode,
  input  logic [ADDR_W-1:0]     phase_inc,
  input  logic [CNT_W-1:0]      burst_cycles,
  input  logic [GAP_W-1:0]      gap_samples,
  input  logic [DATA_W-1:0]     idle_code,
  dac_burst_sequencer_if.master wave,
  output logic                  busy,
  output logic                  burst_done,
  output logic [CNT_W-1:0]      cycle_count
);

  typedef enum logic [1:0] {WAIT_CFG, IDLE, PLAY, GAP} state_t;

  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W:0]    CNT_ONE  = {{CNT_W{1'b0}}, 1'b1};
  localparam logic [GAP_W:0]    GAP_ONE  = {{GAP_W{1'b0}}, 1'b1};

  state_t state_q, state_d;

  logic cfg_s1_q, cfg_s2_q;
  logic trig_s1_q, trig_s2_q, trig_s3_q;
  logic trig_rise;

  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [ADDR_W-1:0] inc_q, inc_d;
  logic [CNT_W-1:0]  burst_q, burst_d;
  logic [CNT_W-1:0]  cycle_count_q, cycle_count_d;
  logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
  logic              v_q, v_d;
  logic [DATA_W-1:0] dac_data_q, dac_data_d;
  logic              busy_q, busy_d;
  logic              burst_done_q, burst_done_d;

  logic [ADDR_W:0]   addr_sum;
  logic [CNT_W:0]    cnt_inc;
  logic [GAP_W:0]    gap_inc;
  logic              carry, last_cycle, cfg_lost, retrig, gap_end, start_play;

  // Both async inputs are only ever used through these synchronisers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_s1_q  <= 1'b0;
      cfg_s2_q  <= 1'b0;
      trig_s1_q <= 1'b0;
      trig_s2_q <= 1'b0;
      trig_s3_q <= 1'b0;
    end else begin
      cfg_s1_q  <= config_done;
      cfg_s2_q  <= cfg_s1_q;
      trig_s1_q <= trig_in;
      trig_s2_q <= trig_s1_q;
      trig_s3_q <= trig_s2_q;
    end
  end

  assign trig_rise = trig_s2_q & ~trig_s3_q;

  always_comb begin
    addr_sum   = {1'b0, rom_addr_q} + {1'b0, inc_q};
    carry      = addr_sum[ADDR_W];
    cnt_inc    = {1'b0, cycle_count_q} + CNT_ONE;
    gap_inc    = {1'b0, gap_cnt_q} + GAP_ONE;
    gap_end    = gap_inc >= {1'b0, gap_samples};
    last_cycle = (burst_q != '0) && carry && (cnt_inc == {1'b0, burst_q});
    cfg_lost   = (state_q != WAIT_CFG) && !cfg_s2_q;
`ifdef DAC_SEQ_RETRIG_EN
    retrig     = trig_mode && trig_rise && ((state_q == PLAY) || (state_q == GAP));
`else
    retrig     = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= WAIT_CFG;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    start_play = 1'b0;
    if (cfg_lost) begin
      state_d = WAIT_CFG;
    end else if (retrig) begin
      state_d    = PLAY;
      start_play = 1'b1;
    end else begin
      case (state_q)
        WAIT_CFG: if (cfg_s2_q) state_d = IDLE;
        IDLE: begin
          if (!trig_mode || trig_rise) begin
            state_d    = PLAY;
            start_play = 1'b1;
          end
        end
        PLAY:     if (last_cycle) state_d = (gap_samples != '0) ? GAP : IDLE;
        GAP:      if (gap_end) state_d = IDLE;
        default:  state_d = WAIT_CFG;
      endcase
    end
  end

  always_comb begin
    rom_addr_d    = rom_addr_q;
    inc_d         = inc_q;
    burst_d       = burst_q;
    cycle_count_d = cycle_count_q;
    gap_cnt_d     = gap_cnt_q;
    burst_done_d  = 1'b0;
    v_d           = (state_q == PLAY) && !cfg_lost;

    if (cfg_lost) begin
      rom_addr_d = '0;
    end else if (start_play) begin
      rom_addr_d    = '0;
      inc_d         = (phase_inc == '0) ? ADDR_ONE : phase_inc;
      burst_d       = burst_cycles;
      cycle_count_d = '0;
    end else if (state_q == PLAY) begin
      rom_addr_d = addr_sum[ADDR_W-1:0];
      // A carry out of the address add marks one whole waveform cycle.
      if (carry && !cnt_inc[CNT_W]) cycle_count_d = cnt_inc[CNT_W-1:0];
      if (last_cycle) begin
        rom_addr_d   = '0;
        burst_done_d = 1'b1;
      end
    end

    if (state_q == GAP) gap_cnt_d = gap_inc[GAP_W-1:0];
    else                gap_cnt_d = '0;

    dac_data_d = v_q ? wave.rom_data : idle_code;
    busy_d     = (state_d == PLAY) || (state_d == GAP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_addr_q    <= '0;
      inc_q         <= '0;
      burst_q       <= '0;
      cycle_count_q <= '0;
      gap_cnt_q     <= '0;
      v_q           <= 1'b0;
      dac_data_q    <= '0;
      busy_q        <= 1'b0;
      burst_done_q  <= 1'b0;
    end else begin
      rom_addr_q    <= rom_addr_d;
      inc_q         <= inc_d;
      burst_q       <= burst_d;
      cycle_count_q <= cycle_count_d;
      gap_cnt_q     <= gap_cnt_d;
      v_q           <= v_d;
      dac_data_q    <= dac_data_d;
      busy_q        <= busy_d;
      burst_done_q  <= burst_done_d;
    end
  end

  assign wave.rom_addr = rom_addr_q;
  assign wave.dac_data = dac_data_q;
  assign busy          = busy_q;
  assign burst_done    = burst_done_q;
  assign cycle_count   = cycle_count_q;

endmodule
